spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//   Single-byte SPI master (no chip select in base build): shifts tx_data out on spi_mosi while
//   capturing spi_miso into rx_data, MSB first. SPI clock is derived from the system clock rclk.
//   Sits between a CPU/peripheral register bus and an external SPI slave (e.g. SD card, flash).
// PARAMETERS
//   CPOL         0  idle level of spi_clk (0 or 1)
//   CPHA         0  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//   CLK_DIVIDER  4  rclk cycles per spi_clk period; even, >=2; each half-period = CLK_DIVIDER/2 cycles
// PORTS
//   rclk      in   1  system clock; sole clock, all logic on posedge
//   rst       in   1  synchronous, active-high reset
//   start     in   1  request transfer; level-sampled only while idle
//   tx_data   in   8  byte to send; captured in the cycle start is accepted
//   rx_data   out  8  last received byte; updated at transfer end, held until next end
//   busy      out  1  high while a transfer is in progress
//   ready     out  1  one-cycle strobe: transfer complete, rx_data valid
//   spi_clk   out  1  SPI serial clock
//   spi_mosi  out  1  master out
//   spi_miso  in   1  master in
// BEHAVIOUR
//   Reset: state IDLE, spi_clk=CPOL, spi_mosi=0, rx_data=8'h00, busy=0, ready=0.
//   States: IDLE -> XFER -> DONE -> IDLE.
//   IDLE: spi_clk=CPOL. If start=1 on an rclk edge: load shift reg with tx_data, clear bit/divider
//     counters, go XFER; busy=1 from next cycle. CPHA=0: spi_mosi=tx_data[7] from that next cycle.
//   XFER: 8 bits x CLK_DIVIDER cycles = 8*CLK_DIVIDER rclk cycles (32 at default).
//     Per bit: first half spi_clk=CPOL, second half ~CPOL; leading edge = CPOL->~CPOL.
//     CPHA=0: sample spi_miso on leading edge; present next bit on trailing edge.
//     CPHA=1: present bit on leading edge; sample on trailing edge.
//     Samples shift into rx shift reg LSB side (first sampled bit ends as rx_data[7]).
//     After the 8th bit's final half, spi_clk returns to CPOL; go DONE.
//   DONE (1 cycle): rx_data <= rx shift reg, ready=1, busy=0; next cycle IDLE.
//   Latency: start accepted at edge k -> ready high in cycle k+1+8*CLK_DIVIDER.
//   start while busy/DONE: ignored (no queueing). start still high in IDLE after DONE: new transfer.
//   tx_data changes during XFER: no effect. rst mid-transfer: abort, all outputs to reset values.
//   spi_mosi after transfer: holds last driven bit until next start.
// CONFIGURATION
//   SPI_MASTER_CS_EN defined: adds output spi_cs_n (1 bit, active low); reset/IDLE=1, driven 0 from
//     the cycle after start is accepted until the DONE cycle (inclusive), giving >=1/2 SPI period
//     setup before first leading edge and release after last edge. Bit timing unchanged.
//   Not defined: no spi_cs_n port; slave select handled externally (e.g. GPIO).
// STRUCTURE
//   Package spi_master_pkg: state enum (IDLE, XFER, DONE), DATA_W=8, bit-counter width, divider
//     counter width function of CLK_DIVIDER.
//   Sub-module spi_clk_gen: divider counter producing spi_clk plus one-cycle leading/trailing edge
//     strobes, enabled only in XFER; spi_master holds FSM and shift registers.
// TESTING
//   Reset 2 cycles -> spi_clk=0, busy=0, ready=0, rx_data=00 (default params).
//   miso tied 1, tx_data=AA, start held 4 cycles -> one transfer only; mosi bits 1,0,1,0,1,0,1,0;
//     ready strobe 33 cycles after accept; rx_data=FF.
//   tx_data=AB, miso driven 1,0,1,0,1,0,1,0 changing on each falling spi_clk -> mosi 10101011,
//     rx_data=AA at ready; start dropped mid-transfer has no effect.
//   Exactly 8 spi_clk rising edges per transfer, period 4 rclk, 50% duty; busy low after ready.
//   rst asserted mid-XFER -> immediate IDLE, spi_clk=CPOL, no ready strobe; next start works.
//   Repeat for CPOL=1/CPHA=1, CLK_DIVIDER=8, and with SPI_MASTER_CS_EN (spi_cs_n framing).

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and sizing helpers for the single-byte SPI master.
// Imported by spi_master_if, spi_clk_gen and spi_master.
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W);

  // Width of a counter that runs 0..clk_divider-1; never narrower than one bit.
  function automatic int div_cnt_w(input int clk_divider);
    return (clk_divider > 2) ? $clog2(clk_divider) : 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Register-bus side of the SPI master: start/tx_data request, rx_data/busy/ready status
// and a debug copy of the FSM state.
interface spi_master_if;
  import spi_master_pkg::*;

  // Handshake: start is level-sampled only while the FSM is IDLE; the rclk edge that
  // sees start=1 in IDLE accepts the request and captures tx_data. busy is high for the
  // whole shift phase, then ready pulses for exactly one cycle with rx_data valid;
  // requests seen while busy or during the ready cycle are dropped, not queued.
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              ready;
  state_t            state;

  modport master (
    output start,
    output tx_data,
    input  rx_data,
    input  busy,
    input  ready,
    input  state
  );

  modport slave (
    input  start,
    input  tx_data,
    output rx_data,
    output busy,
    output ready,
    output state
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock divider: while enabled, produces spi_clk plus one-cycle strobes on the rclk
// edges that create the leading and trailing spi_clk transitions.
module spi_clk_gen
  import spi_master_pkg::*;
#(
  parameter bit CPOL        = 1'b0,
  parameter int CLK_DIVIDER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic spi_clk,
  output logic lead,
  output logic trail
);

  localparam int                CNT_W    = div_cnt_w(CLK_DIVIDER);
  localparam int                HALF     = CLK_DIVIDER / 2;
  localparam logic [CNT_W-1:0]  LEAD_CNT = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLK_DIVIDER - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero whenever disabled so every transfer starts on a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // First half of each bit period sits at CPOL, second half at ~CPOL.
  assign spi_clk = (en && (cnt >= HALF_CNT)) ? ~CPOL : CPOL;
  assign lead    = en && (cnt == LEAD_CNT);
  assign trail   = en && (cnt == LAST_CNT);

endmodule

// File: rtl/spi_master.sv
// Single-byte MSB-first SPI master with IDLE -> XFER -> DONE sequencing.
// Optional build macro SPI_MASTER_CS_EN adds an active-low spi_cs_n framing output.
module spi_master
  import spi_master_pkg::*;
#(
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int CLK_DIVIDER = 4
) (
  input  logic         rclk,
  input  logic         rst,
  spi_master_if.slave  bus,
  output logic         spi_clk,
  output logic         spi_mosi,
  input  logic         spi_miso
`ifdef SPI_MASTER_CS_EN
  ,
  output logic         spi_cs_n
`endif
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  state_t               state_q;
  state_t               state_d;
  logic [DATA_W-1:0]    tx_sr;
  logic [DATA_W-1:0]    rx_sr;
  logic [DATA_W-1:0]    rx_next;
  logic [DATA_W-1:0]    rx_data_q;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 mosi_q;
  logic                 clk_en;
  logic                 lead;
  logic                 trail;
  logic                 last_trail;
  logic                 shift_evt;
  logic                 sample_evt;

  assign clk_en = (state_q == XFER);

  spi_clk_gen #(
    .CPOL        (CPOL),
    .CLK_DIVIDER (CLK_DIVIDER)
  ) u_clk_gen (
    .clk     (rclk),
    .rst     (rst),
    .en      (clk_en),
    .spi_clk (spi_clk),
    .lead    (lead),
    .trail   (trail)
  );

  assign last_trail = trail && (bit_cnt == LAST_BIT);

  // tx_sr[MSB] is always the next bit to present. With CPHA=0 the first bit goes out at
  // accept time, so the register is loaded pre-shifted and the final trailing edge must
  // leave spi_mosi holding bit 0.
  assign shift_evt  = CPHA ? lead : (trail && !last_trail);
  assign sample_evt = CPHA ? trail : lead;
  assign rx_next    = sample_evt ? {rx_sr[DATA_W-2:0], spi_miso} : rx_sr;

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = XFER;
      XFER:    if (last_trail) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_data_q <= '0;
      bit_cnt   <= '0;
      mosi_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        tx_sr   <= CPHA ? bus.tx_data : {bus.tx_data[DATA_W-2:0], 1'b0};
        bit_cnt <= '0;
        if (!CPHA) mosi_q <= bus.tx_data[DATA_W-1];
      end
      if (shift_evt) begin
        mosi_q <= tx_sr[DATA_W-1];
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      end
      if (sample_evt) rx_sr <= rx_next;
      if (trail) bit_cnt <= bit_cnt + 1'b1;
      // With CPHA=1 the last sample lands on this same edge, hence rx_next.
      if (last_trail) rx_data_q <= rx_next;
    end
  end

  assign spi_mosi    = mosi_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = (state_q == XFER);
  assign bus.ready   = (state_q == DONE);
  assign bus.state   = state_q;

`ifdef SPI_MASTER_CS_EN
  // Asserted for the whole XFER plus the DONE cycle, framing all eight bits.
  assign spi_cs_n = !((state_q == XFER) || (state_q == DONE));
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed/random bench for spi_master over three configurations:
// (CPOL,CPHA,DIV) = (0,0,4), (1,1,8), (1,0,2); define SPI_MASTER_CS_EN to also check spi_cs_n.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int N = 3;

  logic       rclk;
  logic       rst;
  logic       start_v [N];
  logic [7:0] tx_v    [N];
  logic       miso_v  [N];
  logic       clk_o   [N];
  logic       mosi_o  [N];
  logic       busy_o  [N];
  logic       ready_o [N];
  logic [7:0] rx_o    [N];
  state_t     state_o [N];
  logic       cs_o    [N];

  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cur_s = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_master_if bus ();
    assign bus.start   = start_v[g];
    assign bus.tx_data = tx_v[g];
    assign busy_o[g]   = bus.busy;
    assign ready_o[g]  = bus.ready;
    assign rx_o[g]     = bus.rx_data;
    assign state_o[g]  = bus.state;
`ifndef SPI_MASTER_CS_EN
    assign cs_o[g] = 1'b1;
`endif
    spi_master #(
      .CPOL        (g != 0),
      .CPHA        (g == 1),
      .CLK_DIVIDER ((g == 0) ? 4 : ((g == 1) ? 8 : 2))
    ) dut (
      .rclk     (rclk),
      .rst      (rst),
      .bus      (bus),
      .spi_clk  (clk_o[g]),
      .spi_mosi (mosi_o[g]),
      .spi_miso (miso_v[g])
`ifdef SPI_MASTER_CS_EN
      ,
      .spi_cs_n (cs_o[g])
`endif
    );
  end

  function automatic logic cpol_of(input int s); return s != 0; endfunction
  function automatic logic cpha_of(input int s); return s == 1; endfunction
  function automatic int   div_of (input int s); return (s == 0) ? 4 : ((s == 1) ? 8 : 2); endfunction

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #3_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[cfg%0d] got=%0h exp=%0h", tag, cur_s, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int s);
    cur_s = s;
    chk("rst_spi_clk", 32'(clk_o[s]), 32'(cpol_of(s)));
    chk("rst_mosi",    32'(mosi_o[s]), 32'd0);
    chk("rst_busy",    32'(busy_o[s]), 32'd0);
    chk("rst_ready",   32'(ready_o[s]), 32'd0);
    chk("rst_rx_data", 32'(rx_o[s]), 32'd0);
    chk("rst_state",   32'(state_o[s]), 32'(IDLE));
`ifdef SPI_MASTER_CS_EN
    chk("rst_cs_n",    32'(cs_o[s]), 32'd1);
`endif
  endtask

  // ---------------- driver + slave model ----------------
  // Acts as an SPI slave: presents miso bits MSB first on the edge opposite to the
  // master's sampling edge and collects mosi on the master's presenting edge's opposite.
  task automatic xfer(input int s, input logic [7:0] tx, input logic [7:0] mpat, input int hold);
    int         d         = div_of(s);
    logic       pol       = cpol_of(s);
    logic       pha       = cpha_of(s);
    int         rdy_at    = -1;
    int         lead_n    = 0;
    int         last_lead = -1;
    int         per_bad   = 0;
    int         hi_n      = 0;
    int         busy_n    = 0;
    int         cs_lo     = 0;
    int         extra     = 0;
    int         mi        = pha ? 7 : 6;
    logic [7:0] mosi_got  = '0;
    logic       prev;
    cur_s = s;
    @(negedge rclk);
    tx_v[s]    = tx;
    start_v[s] = 1'b1;
    if (!pha) miso_v[s] = mpat[7];
    exp_q.push_back(mpat);
    prev = clk_o[s];
    for (int c = 1; c <= 8 * d + 4 && rdy_at < 0; c++) begin
      @(negedge rclk);
      if (c == hold) start_v[s] = 1'b0;
      if (c == 3) tx_v[s] = ~tx;
      if (c == 1) begin
        chk("busy_first", 32'(busy_o[s]), 32'd1);
        if (!pha) chk("mosi_first", 32'(mosi_o[s]), 32'(tx[7]));
      end
      if (busy_o[s]) busy_n++;
      if (clk_o[s] !== pol) hi_n++;
      if (!cs_o[s]) cs_lo++;
      if (prev === pol && clk_o[s] !== pol) begin
        lead_n++;
        if (last_lead >= 0 && (c - last_lead) != d) per_bad++;
        last_lead = c;
        if (!pha) mosi_got = {mosi_got[6:0], mosi_o[s]};
        else if (mi >= 0) begin miso_v[s] = mpat[mi]; mi--; end
      end else if (prev !== pol && clk_o[s] === pol) begin
        if (pha) mosi_got = {mosi_got[6:0], mosi_o[s]};
        else if (mi >= 0) begin miso_v[s] = mpat[mi]; mi--; end
      end
      prev = clk_o[s];
      if (ready_o[s]) begin
        rdy_at = c;
        chk("busy_at_ready", 32'(busy_o[s]), 32'd0);
        if (exp_q.size() > 0) chk("rx_data", 32'(rx_o[s]), 32'(exp_q.pop_front()));
      end
    end
    start_v[s] = 1'b0;
    chk("ready_latency", 32'(rdy_at), 32'(1 + 8 * d));
    chk("lead_edges",    32'(lead_n), 32'd8);
    chk("period_errs",   32'(per_bad), 32'd0);
    chk("high_cycles",   32'(hi_n), 32'(4 * d));
    chk("busy_cycles",   32'(busy_n), 32'(8 * d));
    chk("mosi_byte",     32'(mosi_got), 32'(tx));
`ifdef SPI_MASTER_CS_EN
    chk("cs_low_cycles", 32'(cs_lo), 32'(8 * d + 1));
`endif
    repeat (4) begin
      @(negedge rclk);
      if (ready_o[s] || busy_o[s]) extra++;
    end
    chk("no_second_xfer", 32'(extra), 32'd0);
    chk("spi_clk_idle",   32'(clk_o[s]), 32'(pol));
    chk("rx_data_held",   32'(rx_o[s]), 32'(mpat));
    chk("mosi_hold",      32'(mosi_o[s]), 32'(tx[0]));
  endtask

  task automatic abort_xfer(input int s);
    int seen = 0;
    cur_s = s;
    @(negedge rclk);
    tx_v[s]    = 8'h5A;
    start_v[s] = 1'b1;
    @(negedge rclk);
    start_v[s] = 1'b0;
    repeat (3 * div_of(s) + 1) @(negedge rclk);
    chk("abort_busy_before", 32'(busy_o[s]), 32'd1);
    rst = 1'b1;
    @(negedge rclk);
    chk_reset_outputs(s);
    rst = 1'b0;
    repeat (8 * div_of(s) + 4) begin
      @(negedge rclk);
      if (ready_o[s]) seen++;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0;
      tx_v[i]    = '0;
      miso_v[i]  = 1'b0;
    end
    repeat (2) @(negedge rclk);
    for (int i = 0; i < N; i++) chk_reset_outputs(i);
    rst = 1'b0;

    for (int s = 0; s < N; s++) begin
      miso_v[s] = 1'b1;
      xfer(s, 8'hAA, 8'hFF, 4);
      xfer(s, 8'hAB, 8'hAA, 10);
      xfer(s, 8'h00, 8'h81, 1);
      xfer(s, 8'hFF, 8'h00, 2);
      repeat (3) begin
        r_tx = 8'($urandom_range(0, 255));
        r_rx = 8'($urandom_range(0, 255));
        xfer(s, r_tx, r_rx, $urandom_range(1, 8));
      end
      abort_xfer(s);
      xfer(s, 8'h3C, 8'hC5, 3);
    end

    cur_s = 0;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
